// File: rtl/mc_ctrl_hs.sv
// Multi-cycle MIPS control FSM with variable-latency memory handshake,
// bne/ori decode, an illegal-instruction exception state and a retire counter.
module mc_ctrl_hs #(
   parameter int ALUOP_W       = 4,
   parameter int CNT_W         = 32,
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter bit EXC_ENABLE    = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         OpCode,
   input  logic [5:0]         Funct,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               BranchNE,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic [1:0]         MemtoReg,
   output logic [1:0]         RegDst,
   output logic               RegWrite,
   output logic               ExtOp,
   output logic               LuiOp,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [1:0]         PCSource,
   output logic [2:0]         state_o,
   output logic               exc,
   output logic               instr_retired,
   output logic [CNT_W-1:0]   retired_cnt
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4,
      S_EXC = 3'd5
   } state_t;

   localparam logic [5:0] OP_R    = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQ  = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ADDIU= 6'h09, OP_SLTI = 6'h0a, OP_SLTIU= 6'h0b;
   localparam logic [5:0] OP_ANDI = 6'h0c, OP_ORI  = 6'h0d, OP_LUI  = 6'h0f;
   localparam logic [5:0] OP_LW   = 6'h23, OP_SW   = 6'h2b;

   state_t     state, nxt;
   logic       rdy, retire, is_r, legal, legal_r, legal_i, is_shift, is_jr, is_jalr;
   logic [3:0] alu;

   assign rdy      = MEM_HANDSHAKE ? mem_ready : 1'b1;
   assign is_r     = (OpCode == OP_R);
   assign is_shift = (Funct == 6'h00) || (Funct == 6'h02) || (Funct == 6'h03);
   assign is_jr    = (Funct == 6'h08);
   assign is_jalr  = (Funct == 6'h09);
   assign legal    = is_r ? legal_r : legal_i;

   always_comb begin
      legal_r = 1'b0;
      case (Funct)
         6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22,
         6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: legal_r = 1'b1;
         default: legal_r = 1'b0;
      endcase
   end

   always_comb begin
      legal_i = 1'b0;
      case (OpCode)
         OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: legal_i = 1'b1;
         default: legal_i = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IF;
         retired_cnt <= '0;
      end else begin
         state <= nxt;
         if (retire) retired_cnt <= retired_cnt + 1'b1;
      end
   end

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BranchNE    = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 2'b00;
      RegDst      = 2'b00;
      RegWrite    = 1'b0;
      ExtOp       = 1'b0;
      LuiOp       = 1'b0;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      alu         = 4'b0000;
      PCSource    = 2'b00;
      exc         = 1'b0;
      retire      = 1'b0;
      nxt         = S_IF;
      // Outputs stay at their zero defaults while reset is held.
      if (!reset) begin
         case (state)
            S_IF: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               IRWrite = rdy;
               PCWrite = rdy;
               nxt     = rdy ? S_ID : S_IF;
            end
            S_ID: begin
               ALUSrcB = 2'b11;
               ExtOp   = 1'b1;
               if (legal)           nxt = S_EX;
               else if (EXC_ENABLE) nxt = S_EXC;
               else                 retire = 1'b1;
            end
            S_EX: begin
               if (is_r) begin
                  ALUSrcA = is_shift ? 2'b10 : 2'b01;
                  alu     = 4'b0011;
                  nxt     = S_WB;
                  if (is_jr || is_jalr) begin
                     PCWrite = 1'b1;
                     retire  = 1'b1;
                     nxt     = S_IF;
                  end
                  if (is_jalr) begin
                     RegWrite = 1'b1;
                     RegDst   = 2'b01;
                     MemtoReg = 2'b10;
                  end
               end else begin
                  case (OpCode)
                     OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI: begin
                        ALUSrcA = 2'b01;
                        ALUSrcB = 2'b10;
                        ExtOp   = !(OpCode == OP_ANDI || OpCode == OP_ORI);
                        LuiOp   = (OpCode == OP_LUI);
                        case (OpCode)
                           OP_ADDI:  alu = 4'b0100;
                           OP_SLTI:  alu = 4'b0101;
                           OP_SLTIU: alu = 4'b0001;
                           OP_ANDI:  alu = 4'b0010;
                           OP_ORI:   alu = 4'b0110;
                           default:  alu = 4'b0000;
                        endcase
                        nxt = S_WB;
                     end
                     OP_LW, OP_SW: begin
                        ALUSrcA = 2'b01;
                        ALUSrcB = 2'b10;
                        ExtOp   = 1'b1;
                        alu     = 4'b0100;
                        nxt     = S_MEM;
                     end
                     OP_BEQ, OP_BNE: begin
                        ALUSrcA     = 2'b01;
                        alu         = 4'b0111;
                        PCWriteCond = 1'b1;
                        PCSource    = 2'b01;
                        BranchNE    = (OpCode == OP_BNE);
                        retire      = 1'b1;
                     end
                     OP_J, OP_JAL: begin
                        PCWrite  = 1'b1;
                        PCSource = 2'b10;
                        retire   = 1'b1;
                        if (OpCode == OP_JAL) begin
                           RegWrite = 1'b1;
                           RegDst   = 2'b10;
                           MemtoReg = 2'b10;
                        end
                     end
                     default: nxt = S_IF;
                  endcase
               end
            end
            S_MEM: begin
               IorD     = 1'b1;
               MemWrite = (OpCode == OP_SW);
               MemRead  = (OpCode == OP_LW);
               if (!rdy)                     nxt = S_MEM;
               else if (OpCode == OP_SW)     retire = 1'b1;
               else                          nxt = S_WB;
            end
            S_WB: begin
               RegWrite = 1'b1;
               if (is_r) begin
                  RegDst   = 2'b01;
                  MemtoReg = 2'b01;
               end else if (OpCode != OP_LW) begin
                  MemtoReg = 2'b01;
               end
               retire = 1'b1;
            end
            S_EXC: begin
               PCWrite  = 1'b1;
               PCSource = 2'b11;
               exc      = 1'b1;
            end
            default: nxt = S_IF;
         endcase
      end
   end

   assign ALUOp         = ALUOP_W'(alu);
   assign instr_retired = retire;
   assign state_o       = reset ? 3'd0 : state;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Scoreboard bench for mc_ctrl_hs: default instance plus one with EXC disabled
// and a 4-bit retire counter; expected per-cycle control vectors are queued.
module tb_mc_ctrl_hs;

   typedef struct packed {
      logic [31:0] cnt;
      logic [2:0]  st;
      logic        pcw, pcwc, bne, iord, mr, mw, irw;
      logic [1:0]  m2r, rdst;
      logic        rw, ext, lui;
      logic [1:0]  asa, asb;
      logic [3:0]  aop;
      logic [1:0]  pcs;
      logic        exc, ret;
   } ctl_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, rst1, rdy0, rdy1;
   logic [5:0] op0, fn0, op1, fn1;

   logic pcw0, pcwc0, bne0, iord0, mr0, mw0, irw0, rw0, ext0, lui0, exc0, ret0;
   logic [1:0] m2r0, rdst0, asa0, asb0, pcs0;
   logic [3:0] aop0;
   logic [2:0] st0;
   logic [31:0] cnt0;

   logic pcw1, pcwc1, bne1, iord1, mr1, mw1, irw1, rw1, ext1, lui1, exc1, ret1;
   logic [1:0] m2r1, rdst1, asa1, asb1, pcs1;
   logic [3:0] aop1;
   logic [2:0] st1;
   logic [3:0] cnt1;

   mc_ctrl_hs u_dut0 (
      .clk(clk), .reset(rst0), .OpCode(op0), .Funct(fn0), .mem_ready(rdy0),
      .PCWrite(pcw0), .PCWriteCond(pcwc0), .BranchNE(bne0), .IorD(iord0),
      .MemRead(mr0), .MemWrite(mw0), .IRWrite(irw0), .MemtoReg(m2r0),
      .RegDst(rdst0), .RegWrite(rw0), .ExtOp(ext0), .LuiOp(lui0),
      .ALUSrcA(asa0), .ALUSrcB(asb0), .ALUOp(aop0), .PCSource(pcs0),
      .state_o(st0), .exc(exc0), .instr_retired(ret0), .retired_cnt(cnt0)
   );

   mc_ctrl_hs #(.CNT_W(4), .EXC_ENABLE(1'b0)) u_dut1 (
      .clk(clk), .reset(rst1), .OpCode(op1), .Funct(fn1), .mem_ready(rdy1),
      .PCWrite(pcw1), .PCWriteCond(pcwc1), .BranchNE(bne1), .IorD(iord1),
      .MemRead(mr1), .MemWrite(mw1), .IRWrite(irw1), .MemtoReg(m2r1),
      .RegDst(rdst1), .RegWrite(rw1), .ExtOp(ext1), .LuiOp(lui1),
      .ALUSrcA(asa1), .ALUSrcB(asb1), .ALUOp(aop1), .PCSource(pcs1),
      .state_o(st1), .exc(exc1), .instr_retired(ret1), .retired_cnt(cnt1)
   );

   ctl_t  sb0[$], sb1[$];
   string nm0[$], nm1[$];
   bit    done = 1'b0;
   int    n_cmp = 0, n_bad = 0;

   function automatic ctl_t z(input logic [2:0] st, input logic [31:0] c);
      ctl_t x;
      x = '0;
      x.st  = st;
      x.cnt = c;
      return x;
   endfunction

   function automatic ctl_t f_if(input logic r, input logic [31:0] c);
      ctl_t x;
      x = z(3'd0, c);
      x.mr = 1'b1; x.asb = 2'b01; x.irw = r; x.pcw = r;
      return x;
   endfunction

   function automatic ctl_t f_id(input logic [31:0] c);
      ctl_t x;
      x = z(3'd1, c);
      x.asb = 2'b11; x.ext = 1'b1;
      return x;
   endfunction

   task automatic step(input int d, input string nm, input ctl_t x, input logic r);
      if (d == 0) begin
         rdy0 = r; sb0.push_back(x); nm0.push_back(nm);
      end else begin
         rdy1 = r; sb1.push_back(x); nm1.push_back(nm);
      end
      @(posedge clk); #1;
   endtask

   // Monitor: pops one expected vector per sampled cycle per instance.
   initial begin : monitor
      ctl_t e, a;
      string s;
      forever begin
         @(negedge clk);
         if (sb0.size() > 0) begin
            e = sb0.pop_front(); s = nm0.pop_front();
            a = {cnt0, st0, pcw0, pcwc0, bne0, iord0, mr0, mw0, irw0, m2r0, rdst0,
                 rw0, ext0, lui0, asa0, asb0, aop0, pcs0, exc0, ret0};
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL dut0 %s: got %h expected %h", s, a, e);
            end
         end
         if (sb1.size() > 0) begin
            e = sb1.pop_front(); s = nm1.pop_front();
            a = {28'd0, cnt1, st1, pcw1, pcwc1, bne1, iord1, mr1, mw1, irw1, m2r1, rdst1,
                 rw1, ext1, lui1, asa1, asb1, aop1, pcs1, exc1, ret1};
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL dut1 %s: got %h expected %h", s, a, e);
            end
         end
         if (done) begin
            n_cmp++;
            if (sb0.size() + sb1.size() != 0) begin
               n_bad++;
               $display("FAIL drain: got %0d pending expected 0", sb0.size() + sb1.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL timeout: got no completion expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      ctl_t x;
      logic [31:0] c;
      rst0 = 1'b1; rst1 = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0;
      op0 = 6'h00; fn0 = 6'h00; op1 = 6'h00; fn1 = 6'h00;
      @(posedge clk); #1;
      step(0, "reset", z(3'd0, 0), 1'b1);
      step(0, "reset", z(3'd0, 0), 1'b1);
      rst0 = 1'b0;

      // add
      op0 = 6'h00; fn0 = 6'h20;
      step(0, "add IF", f_if(1, 0), 1);
      step(0, "add ID", f_id(0), 1);
      x = z(3'd2, 0); x.asa = 2'b01; x.aop = 4'b0011;
      step(0, "add EX", x, 1);
      x = z(3'd4, 0); x.rw = 1; x.rdst = 2'b01; x.m2r = 2'b01; x.ret = 1;
      step(0, "add WB", x, 1);

      // lw with 3 IF and 2 MEM wait cycles
      op0 = 6'h23;
      for (int i = 0; i < 3; i++) step(0, "lw IF wait", f_if(0, 1), 0);
      step(0, "lw IF rdy", f_if(1, 1), 1);
      step(0, "lw ID", f_id(1), 1);
      x = z(3'd2, 1); x.asa = 2'b01; x.asb = 2'b10; x.ext = 1; x.aop = 4'b0100;
      step(0, "lw EX", x, 1);
      x = z(3'd3, 1); x.iord = 1; x.mr = 1;
      step(0, "lw MEM wait", x, 0);
      step(0, "lw MEM wait", x, 0);
      step(0, "lw MEM rdy", x, 1);
      x = z(3'd4, 1); x.rw = 1; x.ret = 1;
      step(0, "lw WB", x, 1);

      // bne then beq
      op0 = 6'h05;
      step(0, "bne IF", f_if(1, 2), 1);
      step(0, "bne ID", f_id(2), 1);
      x = z(3'd2, 2); x.asa = 2'b01; x.aop = 4'b0111; x.pcwc = 1; x.pcs = 2'b01;
      x.bne = 1; x.ret = 1;
      step(0, "bne EX", x, 1);
      op0 = 6'h04;
      step(0, "beq IF", f_if(1, 3), 1);
      step(0, "beq ID", f_id(3), 1);
      x.cnt = 3; x.bne = 0;
      step(0, "beq EX", x, 1);

      // illegal opcode -> EXC, no retire
      op0 = 6'h3f;
      step(0, "ill IF", f_if(1, 4), 1);
      step(0, "ill ID", f_id(4), 1);
      x = z(3'd5, 4); x.pcw = 1; x.pcs = 2'b11; x.exc = 1;
      step(0, "ill EXC", x, 1);

      // sw with one MEM wait
      op0 = 6'h2b;
      step(0, "sw IF", f_if(1, 4), 1);
      step(0, "sw ID", f_id(4), 1);
      x = z(3'd2, 4); x.asa = 2'b01; x.asb = 2'b10; x.ext = 1; x.aop = 4'b0100;
      step(0, "sw EX", x, 1);
      x = z(3'd3, 4); x.iord = 1; x.mw = 1;
      step(0, "sw MEM wait", x, 0);
      x.ret = 1;
      step(0, "sw MEM rdy", x, 1);

      // jal
      op0 = 6'h03;
      step(0, "jal IF", f_if(1, 5), 1);
      step(0, "jal ID", f_id(5), 1);
      x = z(3'd2, 5); x.pcw = 1; x.pcs = 2'b10; x.rw = 1; x.rdst = 2'b10;
      x.m2r = 2'b10; x.ret = 1;
      step(0, "jal EX", x, 1);

      // ori (zero-extend)
      op0 = 6'h0d;
      step(0, "ori IF", f_if(1, 6), 1);
      step(0, "ori ID", f_id(6), 1);
      x = z(3'd2, 6); x.asa = 2'b01; x.asb = 2'b10; x.aop = 4'b0110;
      step(0, "ori EX", x, 1);
      x = z(3'd4, 6); x.rw = 1; x.m2r = 2'b01; x.ret = 1;
      step(0, "ori WB", x, 1);

      // jr
      op0 = 6'h00; fn0 = 6'h08;
      step(0, "jr IF", f_if(1, 7), 1);
      step(0, "jr ID", f_id(7), 1);
      x = z(3'd2, 7); x.asa = 2'b01; x.aop = 4'b0011; x.pcw = 1; x.ret = 1;
      step(0, "jr EX", x, 1);

      // lw abandoned by reset while waiting in MEM
      op0 = 6'h23;
      step(0, "lwr IF", f_if(1, 8), 1);
      step(0, "lwr ID", f_id(8), 1);
      x = z(3'd2, 8); x.asa = 2'b01; x.asb = 2'b10; x.ext = 1; x.aop = 4'b0100;
      step(0, "lwr EX", x, 0);
      x = z(3'd3, 8); x.iord = 1; x.mr = 1;
      step(0, "lwr MEM wait", x, 0);
      rst0 = 1'b1;
      step(0, "lwr in reset", z(3'd0, 0), 0);
      step(0, "lwr in reset", z(3'd0, 0), 1);
      rst0 = 1'b0;
      step(0, "post-reset IF", f_if(0, 0), 0);

      // EXC disabled: illegal retires from ID; then 16 jumps wrap a 4-bit count
      rst1 = 1'b0;
      op1 = 6'h3f;
      step(1, "ill IF", f_if(1, 0), 1);
      x = f_id(0); x.ret = 1;
      step(1, "ill ID retire", x, 1);
      op1 = 6'h02;
      for (int i = 0; i < 16; i++) begin
         c = (1 + i) % 16;
         step(1, "j IF", f_if(1, c), 1);
         step(1, "j ID", f_id(c), 1);
         x = z(3'd2, c); x.pcw = 1; x.pcs = 2'b10; x.ret = 1;
         step(1, "j EX", x, 1);
      end
      step(1, "wrap IF", f_if(0, 1), 0);
      done = 1'b1;
   end

endmodule
